// File: rtl/lsu_pkg.sv
// Shared definitions for the memory-access unit: funct3 encodings, FSM state
// encoding and access-size helpers.
package lsu_pkg;

   // RV32I load/store funct3 encodings
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   // FSM state codes, kept as plain constants so older tooling can reuse them
   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_ACC0 = 3'd1;
   localparam logic [2:0] S_ACC1 = 3'd2;
   localparam logic [2:0] S_WAIT = 3'd3;
   localparam logic [2:0] S_RESP = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE = S_IDLE,
      ST_ACC0 = S_ACC0,
      ST_ACC1 = S_ACC1,
      ST_WAIT = S_WAIT,
      ST_RESP = S_RESP
   } lsu_state_e;

   // Byte-lane mask of an access that starts at lane 0
   function automatic logic [3:0] size_mask(input logic [1:0] sz);
      logic [3:0] m;
      case (sz)
         2'b00:   m = 4'b0001;
         2'b01:   m = 4'b0011;
         2'b10:   m = 4'b1111;
         default: m = 4'b0000;
      endcase
      return m;
   endfunction

   // Number of bytes touched by an access
   function automatic logic [2:0] size_bytes(input logic [1:0] sz);
      logic [2:0] b;
      case (sz)
         2'b00:   b = 3'd1;
         2'b01:   b = 3'd2;
         2'b10:   b = 3'd4;
         default: b = 3'd0;
      endcase
      return b;
   endfunction

   // funct3 values that have no RV32I load/store meaning
   function automatic logic is_illegal(input logic we, input logic [2:0] f3);
      return (f3 == 3'b011) || (f3[2:1] == 2'b11) || (we && f3[2]);
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: places store data/mask across two words and
// extracts/extends load data from the two words read back.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [1:0]  off,
   input  logic [2:0]  funct3,
   input  logic [31:0] wdata,
   input  logic [31:0] lo,
   input  logic [31:0] hi,
   output logic [63:0] wide_d,
   output logic [7:0]  wide_m,
   output logic [31:0] load_data
);

   logic [63:0] shifted;

   // Store placement and load alignment are plain shifts by the byte offset
   always_comb begin
      wide_d  = {32'b0, wdata} << {off, 3'b000};
      wide_m  = {4'b0, size_mask(funct3[1:0])} << off;
      shifted = {hi, lo} >> {off, 3'b000};
   end

   // Truncate to access size and extend according to the load flavour
   always_comb begin
      case (funct3)
         F3_LB:   load_data = {{24{shifted[7]}}, shifted[7:0]};
         F3_LH:   load_data = {{16{shifted[15]}}, shifted[15:0]};
         F3_LBU:  load_data = {24'b0, shifted[7:0]};
         F3_LHU:  load_data = {16'b0, shifted[15:0]};
         default: load_data = shifted[31:0];
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store access stage: one request at a time, splits word-crossing
// accesses into two memory cycles and reports completion with a pulse.
module mem_access_unit
   import lsu_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        resp_split,
   output logic [31:0] mem_addr,
   output logic        mem_ren,
   input  logic [31:0] mem_rdata,
   output logic        mem_wen,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_mask
);

   lsu_state_e  state_reg, state_next;
   logic        we_reg;
   logic [2:0]  funct3_reg;
   logic [1:0]  off_reg;
   logic [31:0] word_a_reg;
   logic [31:0] word_b_reg;
   logic [31:0] wdata_reg;
   logic        split_reg;
   logic        err_reg;
   logic [31:0] lo_reg;
   logic [31:0] rdata_reg;

   logic        accept;
   logic        req_illegal;
   logic        req_split;
   logic [63:0] wide_d;
   logic [7:0]  wide_m;
   logic [31:0] load_data;
   logic [31:0] align_lo;
   logic [31:0] align_hi;

   assign accept = (state_reg == ST_IDLE) && req_valid;

   // Classify the incoming request: illegal encodings skip memory entirely
   always_comb begin
      req_illegal = is_illegal(req_we, req_funct3);
      req_split   = !req_illegal &&
                    (({2'b00, req_addr[1:0]} + {1'b0, size_bytes(req_funct3[1:0])}) > 4'd4);
   end

   // In WAIT the current memory word is either the only word or the high word
   always_comb begin
      align_lo = split_reg ? lo_reg : mem_rdata;
      align_hi = split_reg ? mem_rdata : 32'b0;
   end

   lsu_align u_align (
      .off       (off_reg),
      .funct3    (funct3_reg),
      .wdata     (wdata_reg),
      .lo        (align_lo),
      .hi        (align_hi),
      .wide_d    (wide_d),
      .wide_m    (wide_m),
      .load_data (load_data)
   );

   // Next-state sequencing of the access
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (accept)
               state_next = req_illegal ? ST_RESP : ST_ACC0;
         end
         ST_ACC0: begin
            if (split_reg)
               state_next = ST_ACC1;
            else if (!we_reg)
               state_next = ST_WAIT;
            else
               state_next = ST_RESP;
         end
         ST_ACC1: state_next = we_reg ? ST_RESP : ST_WAIT;
         ST_WAIT: state_next = ST_RESP;
         ST_RESP: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // State register plus request latch and load-data capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= ST_IDLE;
         we_reg     <= 1'b0;
         funct3_reg <= 3'b0;
         off_reg    <= 2'b0;
         word_a_reg <= 32'b0;
         word_b_reg <= 32'b0;
         wdata_reg  <= 32'b0;
         split_reg  <= 1'b0;
         err_reg    <= 1'b0;
         lo_reg     <= 32'b0;
         rdata_reg  <= 32'b0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            we_reg     <= req_we;
            funct3_reg <= req_funct3;
            off_reg    <= req_addr[1:0];
            word_a_reg <= {req_addr[31:2], 2'b00};
            word_b_reg <= {req_addr[31:2], 2'b00} + 32'd4;
            wdata_reg  <= req_wdata;
            split_reg  <= req_split;
            err_reg    <= req_illegal;
            rdata_reg  <= 32'b0;
         end
         if (state_reg == ST_ACC1 && !we_reg)
            lo_reg <= mem_rdata;
         if (state_reg == ST_WAIT)
            rdata_reg <= load_data;
      end
   end

   // Memory and response outputs decoded from state and latched request only
   always_comb begin
      req_ready  = (state_reg == ST_IDLE);
      resp_valid = 1'b0;
      resp_rdata = 32'b0;
      resp_err   = 1'b0;
      resp_split = 1'b0;
      mem_addr   = 32'b0;
      mem_ren    = 1'b0;
      mem_wen    = 1'b0;
      mem_wdata  = 32'b0;
      mem_mask   = 4'b0;
      case (state_reg)
         ST_ACC0: begin
            mem_addr  = word_a_reg;
            mem_ren   = !we_reg;
            mem_wen   = we_reg;
            mem_mask  = wide_m[3:0];
            mem_wdata = we_reg ? wide_d[31:0] : 32'b0;
         end
         ST_ACC1: begin
            mem_addr  = word_b_reg;
            mem_ren   = !we_reg;
            mem_wen   = we_reg;
            mem_mask  = wide_m[7:4];
            mem_wdata = we_reg ? wide_d[63:32] : 32'b0;
         end
         ST_RESP: begin
            resp_valid = 1'b1;
            resp_rdata = rdata_reg;
            resp_err   = err_reg;
            resp_split = split_reg;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed requests push expected
// responses and memory operations; monitors pop and compare.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'b0;
   logic [31:0] req_addr = 32'b0;
   logic [31:0] req_wdata = 32'b0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        resp_split;
   logic [31:0] mem_addr;
   logic        mem_ren;
   logic [31:0] mem_rdata = 32'b0;
   logic        mem_wen;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_mask;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      logic        split;
      int          lat;
      int          acc;
   } resp_t;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  mask;
      logic [31:0] data;
   } op_t;

   resp_t exp_q[$];
   op_t   op_q[$];
   resp_t r_e;
   op_t   o_e;

   logic [31:0] mem [0:1023];
   int cyc = 0;
   int checks = 0;
   int passes = 0;

   mem_access_unit dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .resp_split (resp_split),
      .mem_addr   (mem_addr),
      .mem_ren    (mem_ren),
      .mem_rdata  (mem_rdata),
      .mem_wen    (mem_wen),
      .mem_wdata  (mem_wdata),
      .mem_mask   (mem_mask)
   );

   always #5 clk = ~clk;

   // Cycle counter used for latency measurement
   always @(posedge clk) cyc <= cyc + 1;

   // Memory model: registered read, byte-masked write
   always @(posedge clk) begin
      if (mem_ren)
         mem_rdata <= mem[mem_addr[11:2]];
      if (mem_wen)
         for (int b = 0; b < 4; b++)
            if (mem_mask[b])
               mem[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp)
         passes++;
      else
         $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
   endtask

   // Response monitor
   always @(negedge clk) begin
      if (resp_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_resp: got resp_valid=1 expected no response (t=%0t)", $time);
         end else begin
            r_e = exp_q.pop_front();
            $display("resp rdata=%08h err=%0b split=%0b lat=%0d", resp_rdata, resp_err,
                     resp_split, cyc - r_e.acc + 1);
            chk("resp_rdata", resp_rdata, r_e.rdata);
            chk("resp_err", {31'b0, resp_err}, {31'b0, r_e.err});
            chk("resp_split", {31'b0, resp_split}, {31'b0, r_e.split});
            chk("resp_latency", cyc - r_e.acc + 1, r_e.lat);
         end
      end
   end

   // Memory-port monitor
   always @(negedge clk) begin
      if (mem_ren || mem_wen) begin
         $display("mem %s addr=%08h mask=%04b data=%08h", mem_wen ? "W" : "R", mem_addr,
                  mem_mask, mem_wdata);
         chk("mem_ren_wen_exclusive", {31'b0, mem_ren && mem_wen}, 32'd0);
         chk("mem_addr_aligned", {30'b0, mem_addr[1:0]}, 32'd0);
         if (op_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_mem_op: got access at %08h expected none", mem_addr);
         end else begin
            o_e = op_q.pop_front();
            chk("mem_we", {31'b0, mem_wen}, {31'b0, o_e.we});
            chk("mem_addr", mem_addr, o_e.addr);
            if (o_e.we) begin
               chk("mem_mask", {28'b0, mem_mask}, {28'b0, o_e.mask});
               chk("mem_wdata", mem_wdata, o_e.data);
            end
         end
      end
   end

   task automatic push_op(input logic we, input logic [31:0] addr, input logic [3:0] mask,
                          input logic [31:0] data);
      op_q.push_back('{we: we, addr: addr, mask: mask, data: data});
   endtask

   task automatic wait_done();
      for (int i = 0; i < 30 && exp_q.size() != 0; i++)
         @(negedge clk);
      if (exp_q.size() != 0) begin
         checks++;
         $display("FAIL resp_timeout: got %0d pending expected 0", exp_q.size());
         exp_q.delete();
      end
      @(negedge clk);
      @(negedge clk);
      if (op_q.size() != 0) begin
         checks++;
         $display("FAIL mem_op_missing: got %0d pending expected 0", op_q.size());
         op_q.delete();
      end
   endtask

   task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] er, input logic ee,
                         input logic es, input int el, input bit expect_resp);
      int n;
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         checks++;
         $display("FAIL req_ready_timeout: got 0 expected 1");
         return;
      end
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wd;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      if (expect_resp)
         exp_q.push_back('{rdata: er, err: ee, split: es, lat: el, acc: cyc});
      if (expect_resp)
         wait_done();
   endtask

   initial begin
      for (int i = 0; i < 1024; i++)
         mem[i] <= 32'h0;
      #1;
      mem[12'h100 >> 2] <= 32'hDEADBEEF;
      mem[12'h200 >> 2] <= 32'h80AABBCC;
      mem[12'h204 >> 2] <= 32'h11223380;
      mem[10'h3FF]      <= 32'h7F000000;
      mem[0]            <= 32'h00000012;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
      chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
      chk("rst_mem_en", {30'b0, mem_ren, mem_wen}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata_mask", mem_wdata | {28'b0, mem_mask}, 32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Aligned loads
      push_op(0, 32'h100, 4'h0, 32'h0);
      do_req(0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 3, 1);
      push_op(0, 32'h100, 4'h0, 32'h0);
      do_req(0, 3'b000, 32'h101, 32'h0, 32'hFFFFFFBE, 0, 0, 3, 1);
      push_op(0, 32'h100, 4'h0, 32'h0);
      do_req(0, 3'b100, 32'h103, 32'h0, 32'h000000DE, 0, 0, 3, 1);

      // Split loads
      push_op(0, 32'h200, 4'h0, 32'h0);
      push_op(0, 32'h204, 4'h0, 32'h0);
      do_req(0, 3'b001, 32'h203, 32'h0, 32'hFFFF8080, 0, 1, 4, 1);
      push_op(0, 32'h200, 4'h0, 32'h0);
      push_op(0, 32'h204, 4'h0, 32'h0);
      do_req(0, 3'b101, 32'h203, 32'h0, 32'h00008080, 0, 1, 4, 1);
      push_op(0, 32'h200, 4'h0, 32'h0);
      push_op(0, 32'h204, 4'h0, 32'h0);
      do_req(0, 3'b010, 32'h202, 32'h0, 32'h338080AA, 0, 1, 4, 1);

      // Split load wrapping past the top of the address space
      push_op(0, 32'hFFFFFFFC, 4'h0, 32'h0);
      push_op(0, 32'h00000000, 4'h0, 32'h0);
      do_req(0, 3'b001, 32'hFFFFFFFF, 32'h0, 32'h0000127F, 0, 1, 4, 1);

      // Stores, aligned and split, then read back
      push_op(1, 32'h300, 4'b0100, 32'h00A50000);
      do_req(1, 3'b000, 32'h302, 32'h000000A5, 32'h0, 0, 0, 2, 1);
      push_op(1, 32'h400, 4'b1110, 32'h33221100);
      push_op(1, 32'h404, 4'b0001, 32'h00000044);
      do_req(1, 3'b010, 32'h401, 32'h44332211, 32'h0, 0, 1, 3, 1);
      push_op(0, 32'h400, 4'h0, 32'h0);
      push_op(0, 32'h404, 4'h0, 32'h0);
      do_req(0, 3'b010, 32'h401, 32'h0, 32'h44332211, 0, 1, 4, 1);
      push_op(1, 32'h600, 4'b1100, 32'hBEEF0000);
      do_req(1, 3'b001, 32'h602, 32'h1234BEEF, 32'h0, 0, 0, 2, 1);
      push_op(0, 32'h600, 4'h0, 32'h0);
      do_req(0, 3'b001, 32'h602, 32'h0, 32'hFFFFBEEF, 0, 0, 3, 1);

      // Illegal encodings: no memory traffic, error after one cycle
      do_req(0, 3'b011, 32'h100, 32'h0, 32'h0, 1, 0, 1, 1);
      do_req(0, 3'b110, 32'h100, 32'h0, 32'h0, 1, 0, 1, 1);
      do_req(1, 3'b100, 32'h100, 32'hFFFFFFFF, 32'h0, 1, 0, 1, 1);

      // Reset during the second half of a split store
      push_op(1, 32'h500, 4'b1110, 32'hBBCCDD00);
      do_req(1, 3'b010, 32'h501, 32'hAABBCCDD, 32'h0, 0, 1, 3, 0);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_mem_wen", {31'b0, mem_wen}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("midrst_req_ready", {31'b0, req_ready}, 32'd1);
      chk("midrst_word_a", mem[12'h500 >> 2], 32'hBBCCDD00);
      chk("midrst_word_b", mem[12'h504 >> 2], 32'h00000000);
      chk("midrst_ops_done", op_q.size(), 32'd0);
      op_q.delete();
      push_op(0, 32'h500, 4'h0, 32'h0);
      push_op(0, 32'h504, 4'h0, 32'h0);
      do_req(0, 3'b010, 32'h501, 32'h0, 32'h00BBCCDD, 0, 1, 4, 1);

      repeat (4) @(negedge clk);
      chk("resp_queue_empty", exp_q.size(), 32'd0);
      chk("op_queue_empty", op_q.size(), 32'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
